// File: rtl/board_pkg.sv
// board_pkg: block types, agent/status encodings and move classification for the board commit stage
package board_pkg;
  localparam int BOARD_W = 32;
  localparam int BOARD_H = 24;
  localparam int BOARD_CELLS = BOARD_W * BOARD_H;
  localparam logic [3:0] T_EMPTY = 4'h0;
  localparam logic [3:0] T_WALL = 4'h1;
  localparam logic [3:0] T_DOT = 4'h2;
  localparam logic [3:0] T_PAC = 4'h3;
  localparam logic [3:0] T_GHOST0 = 4'h4;
  localparam logic [3:0] T_GHOST3 = 4'h7;
  typedef enum logic [2:0] {PAC, GHOST0, GHOST1, GHOST2, GHOST3} agent_e;
  typedef enum logic [1:0] {MOVED, BLOCKED, CAUGHT} status_e;
  // MOVED here means the target is passable and the write phase may proceed
  function automatic status_e classify_move(input logic [2:0] agent, input logic [3:0] tgt);
    logic ghost_t;
    ghost_t = tgt >= T_GHOST0 && tgt <= T_GHOST3;
    return tgt == T_WALL ? BLOCKED :
           agent == PAC ? (ghost_t ? CAUGHT : MOVED) :
           tgt == T_PAC ? CAUGHT :
           ghost_t ? BLOCKED : MOVED;
  endfunction
endpackage

// File: rtl/board_update_ctrl.sv
// board_update_ctrl: serialises agent moves into read/classify/erase/draw accesses on the shared board RAM
module board_update_ctrl
  import board_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4,
  parameter int NUM_CELLS = 768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_agent,
  input  logic [ADDR_W-1:0] req_from,
  input  logic [ADDR_W-1:0] req_to,
  output logic              resp_valid,
  output logic [1:0]        resp_status,
  output logic              dot_eaten,
  output logic              pac_caught,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR_OLD, WR_NEW, RESP} state_e;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_CELLS);
  state_e state;
  status_e status, cls;
  logic [2:0] agent;
  logic [ADDR_W-1:0] from, to;
  logic [DATA_W-1:0] tgt, old_val, new_val;
  logic [DATA_W-1:0] under [4];
  logic dot, is_pac, reject;
  logic [1:0] gi;
  always_comb begin
    is_pac = agent == PAC;
    gi = 2'(agent - 3'd1);
    old_val = is_pac ? DATA_W'(T_EMPTY) : under[gi];
    new_val = DATA_W'(T_PAC + 4'(agent));
    cls = classify_move(agent, 4'(mem_rdata));
    reject = req_agent > GHOST3 || {1'b0, req_to} >= LIMIT || req_to == req_from;
    req_ready = state == IDLE;
    mem_wren = mem_grant && (state == WR_OLD || state == WR_NEW);
    mem_addr = !mem_grant ? '0 : (state == RD || state == WR_NEW) ? to : state == WR_OLD ? from : '0;
    mem_wdata = !mem_grant ? '0 : state == WR_OLD ? old_val : state == WR_NEW ? new_val : '0;
    resp_valid = state == RESP;
    resp_status = resp_valid ? 2'(status) : 2'd0;
    dot_eaten = resp_valid && dot;
    pac_caught = resp_valid && status == CAUGHT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      status <= MOVED;
      agent <= '0;
      from <= '0;
      to <= '0;
      tgt <= '0;
      dot <= 1'b0;
      for (int i = 0; i < 4; i++) under[i] <= DATA_W'(T_EMPTY);
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          agent <= req_agent;
          from <= req_from;
          to <= req_to;
          dot <= 1'b0;
          status <= BLOCKED;
          state <= reject ? RESP : RD;
        end
        RD: if (mem_grant) state <= CAP;
        CAP: begin
          tgt <= mem_rdata;
          status <= cls;
          state <= cls == MOVED ? WR_OLD : RESP;
        end
        WR_OLD: if (mem_grant) state <= WR_NEW;
        WR_NEW: if (mem_grant) begin
          // ghosts remember only dots; anything else they stood on reappears as empty
          if (is_pac) dot <= tgt == DATA_W'(T_DOT);
          else under[gi] <= tgt == DATA_W'(T_DOT) ? DATA_W'(T_DOT) : DATA_W'(T_EMPTY);
          status <= MOVED;
          state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_update_ctrl.sv
// tb_board_update_ctrl: randomized moves against a board-level reference model, plus directed scenarios
module tb_board_update_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_agent = '0;
  logic [9:0] req_from = '0, req_to = '0;
  logic resp_valid, dot_eaten, pac_caught, mem_wren;
  logic [1:0] resp_status;
  logic mem_grant = 1'b1;
  logic [9:0] mem_addr;
  logic [3:0] mem_wdata, mem_rdata = '0;
  logic poke_en = 1'b0;
  logic [9:0] poke_addr = '0;
  logic [3:0] poke_val = '0;
  logic [3:0] ram [1024];
  logic [3:0] board [1024];
  logic [3:0] under_m [4];
  int checks = 0, errors = 0, cyc = 0, resp_cnt = 0, mode = 0, acc = 0;
  bit hi = 0;
  typedef struct {int st; bit dot; int lat;} exp_t;
  typedef struct {logic [9:0] a; logic [3:0] d;} wr_t;
  exp_t eq[$];
  wr_t wq[$];
  exp_t ce;
  wr_t cw;

  board_update_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_agent(req_agent), .req_from(req_from), .req_to(req_to),
    .resp_valid(resp_valid), .resp_status(resp_status), .dot_eaten(dot_eaten),
    .pac_caught(pac_caught), .mem_grant(mem_grant), .mem_addr(mem_addr),
    .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // board RAM: one-cycle read latency, accesses only on granted cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) ram[poke_addr] <= poke_val;
    else if (mem_grant) begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    mem_grant = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 3) != 0) :
                mode == 2 ? ((cyc / 4) % 2 == 0) : 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (!mem_grant) begin
      chk("wren_without_grant", int'(mem_wren), 0);
      chk("addr_without_grant", int'(mem_addr), 0);
    end
    if (mem_wren) begin
      if (wq.size() == 0) chk("unexpected_write", int'(mem_addr), -1);
      else begin
        cw = wq.pop_front();
        chk("write_addr", int'(mem_addr), int'(cw.a));
        chk("write_data", int'(mem_wdata), int'(cw.d));
      end
    end
    if (resp_valid) begin
      resp_cnt++;
      if (eq.size() == 0) chk("unexpected_resp", int'(resp_status), -1);
      else begin
        ce = eq.pop_front();
        chk("resp_status", int'(resp_status), ce.st);
        chk("dot_eaten", int'(dot_eaten), int'(ce.dot));
        chk("pac_caught", int'(pac_caught), int'(ce.st == 2));
        if (hi) chk("latency", cyc - acc, ce.lat);
      end
    end else chk("stray_pulse", int'(dot_eaten | pac_caught), 0);
    if (!mem_grant) hi = 0;
    if (req_valid && req_ready) begin
      acc = cyc;
      hi = 1;
    end
  end

  // reference: status from the target cell's type, the two writes, and the resulting board
  task automatic model(input logic [2:0] a, input logic [9:0] f, input logic [9:0] t, output exp_t e);
    logic [3:0] v, old;
    bit g;
    e.dot = 0;
    e.st = 1;
    e.lat = 1;
    if (a > 4 || t >= 768 || t == f) return;
    v = board[t];
    g = v >= 4 && v <= 7;
    if (v == 1) e.st = 1;
    else if (a == 0) e.st = g ? 2 : 0;
    else e.st = v == 3 ? 2 : g ? 1 : 0;
    e.lat = e.st == 0 ? 5 : 3;
    if (e.st != 0) return;
    old = a == 0 ? 4'h0 : under_m[a-1];
    wq.push_back('{f, old});
    wq.push_back('{t, 4'(a + 3)});
    board[f] = old;
    board[t] = 4'(a + 3);
    if (a == 0) e.dot = v == 2;
    else under_m[a-1] = v == 2 ? 4'h2 : 4'h0;
  endtask

  task automatic do_req(input logic [2:0] a, input logic [9:0] f, input logic [9:0] t, output exp_t e);
    int n = 0, target;
    while (!req_ready) begin
      @(posedge clk); #1;
      if (++n > 100) begin
        $display("FAIL ready_timeout: req_ready stuck low");
        $fatal(1, "abort");
      end
    end
    model(a, f, t, e);
    eq.push_back(e);
    target = resp_cnt + 1;
    req_valid = 1'b1; req_agent = a; req_from = f; req_to = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_cnt < target) begin
      @(posedge clk); #1;
      if (++n > 500) begin
        $display("FAIL resp_timeout: no resp_valid for agent %0d %0d->%0d", a, f, t);
        $fatal(1, "abort");
      end
    end
  endtask

  task automatic set_cell(input logic [9:0] a, input logic [3:0] v);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    board[a] = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  function automatic logic [3:0] rnd_type();
    int r = $urandom_range(0, 11);
    return r < 3 ? 4'h0 : r < 5 ? 4'h1 : r < 8 ? 4'h2 : r == 8 ? 4'h3 :
           r < 11 ? 4'(4 + $urandom_range(0, 3)) : 4'(8 + $urandom_range(0, 7));
  endfunction

  exp_t e;
  logic [2:0] ra;
  logic [9:0] rf, rt;
  int r;

  initial begin
    for (int i = 0; i < 4; i++) under_m[i] = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_status", int'(resp_status), 0);
    chk("rst_wren", int'(mem_wren), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_pulses", int'(dot_eaten | pac_caught), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) set_cell(10'(i), i < 768 ? rnd_type() : 4'h0);
    reset = 1'b0;
    foreach (set_plan[i]) set_cell(set_plan[i].a, set_plan[i].d);
    do_req(3'd0, 10'd495, 10'd496, e);
    chk("pac_dot_model_status", e.st, 0);
    chk("pac_dot_model_dot", int'(e.dot), 1);
    chk("pac_dot_model_lat", e.lat, 5);
    chk("pac_dot_old_cell", int'(ram[495]), 0);
    chk("pac_dot_new_cell", int'(ram[496]), 3);
    do_req(3'd0, 10'd496, 10'd463, e);
    chk("pac_wall_model_status", e.st, 1);
    chk("pac_wall_model_lat", e.lat, 3);
    chk("pac_wall_cell", int'(ram[463]), 1);
    do_req(3'd1, 10'd299, 10'd300, e);
    do_req(3'd1, 10'd300, 10'd301, e);
    chk("ghost_restores_dot", int'(ram[300]), 2);
    do_req(3'd1, 10'd301, 10'd302, e);
    chk("ghost_leaves_empty", int'(ram[301]), 0);
    chk("ghost_drawn", int'(ram[302]), 4);
    chk("ghost_start_cleared", int'(ram[299]), 0);
    do_req(3'd2, 10'd320, 10'd321, e);
    chk("ghost_catch_model", e.st, 2);
    chk("ghost_catch_pac_kept", int'(ram[321]), 3);
    do_req(3'd0, 10'd496, 10'd497, e);
    chk("pac_into_ghost_model", e.st, 2);
    chk("pac_into_ghost_cell", int'(ram[497]), 6);
    do_req(3'd0, 10'd496, 10'd800, e);
    chk("offboard_model_status", e.st, 1);
    chk("offboard_model_lat", e.lat, 1);
    do_req(3'd6, 10'd496, 10'd495, e);
    chk("bad_agent_model", e.st, 1);
    mode = 2;
    do_req(3'd0, 10'd496, 10'd495, e);
    mode = 0;
    chk("toggled_grant_new", int'(ram[495]), 3);
    chk("toggled_grant_old", int'(ram[496]), 0);
    // abort a move while it is stalled in the erase phase
    @(posedge clk); #1;
    req_valid = 1'b1; req_agent = 3'd0; req_from = 10'd495; req_to = 10'd494;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    mode = 3;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mode = 0;
    for (int i = 0; i < 4; i++) under_m[i] = 4'h0;
    @(negedge clk);
    chk("ready_after_reset", int'(req_ready), 1);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_old_cell", int'(ram[495]), 3);
    chk("abort_new_cell", int'(ram[494]), 0);
    repeat (300) begin
      mode = $urandom_range(0, 2);
      ra = $urandom_range(0, 9) == 0 ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      rf = 10'($urandom_range(0, 767));
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: rt = rf + 10'd1;
        1: rt = rf - 10'd1;
        2: rt = rf + 10'd32;
        default: rt = rf - 10'd32;
      endcase
      if (r == 0) rt = 10'($urandom_range(768, 1023));
      if (r == 1) rt = rf;
      do_req(ra, rf, rt, e);
    end
    mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("writes_drained", wq.size(), 0);
    for (int i = 0; i < 768; i++) chk($sformatf("ram_cell_%0d", i), int'(ram[i]), int'(board[i]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  wr_t set_plan [13] = '{
    '{10'd495, 4'h3}, '{10'd496, 4'h2}, '{10'd463, 4'h1}, '{10'd497, 4'h6},
    '{10'd494, 4'h0}, '{10'd299, 4'h4}, '{10'd300, 4'h2}, '{10'd301, 4'h0},
    '{10'd302, 4'h0}, '{10'd320, 4'h5}, '{10'd321, 4'h3}, '{10'd800, 4'h0},
    '{10'd498, 4'h0}
  };
endmodule

// File: doc/board_update_ctrl.md
Name: board_update_ctrl

Overview:
- Commit stage between the movement logic (Pac-Man behaviour, ghost AI) and the single-port board RAM.
- Accepts one move request at a time and reads the target cell. Then it either rejects the move or erases the old cell and draws the agent in the new one.
- Tracks the tile each ghost is standing on, so dots reappear after a ghost passes.
- Reports per-move status, dot-eaten and caught events. Board RAM access is arbitrated with video scan through a grant input.

Parameters:
- ADDR_W, 10, board cell address width.
- DATA_W, 4, block-type width.
- NUM_CELLS, 768, valid cells (32x24); addresses >= NUM_CELLS are off-board.
- T_EMPTY, 4'h0, empty block type.
- T_WALL, 4'h1, wall block type.
- T_DOT, 4'h2, dot block type.
- T_PAC, 4'h3, Pac-Man block type.
- T_GHOST0, 4'h4, block type of ghost 0; ghost k is drawn as T_GHOST0+k, k=0..3.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- req_valid  in  1  move request present.
- req_ready  out  1  controller idle and able to accept.
- req_agent  in  3  0=Pac-Man, 1..4=ghost 0..3; 5..7 illegal.
- req_from  in  ADDR_W  agent's current cell.
- req_to  in  ADDR_W  requested cell.
- resp_valid  out  1  one-cycle pulse; status valid.
- resp_status  out  2  0=MOVED, 1=BLOCKED, 2=CAUGHT.
- dot_eaten  out  1  one-cycle pulse with resp_valid when Pac-Man moves onto a dot.
- pac_caught  out  1  one-cycle pulse with resp_valid on CAUGHT.
- mem_grant  in  1  board RAM may be driven this cycle.
- mem_addr  out  ADDR_W  board RAM address.
- mem_wren  out  1  board RAM write enable.
- mem_wdata  out  DATA_W  board RAM write data.
- mem_rdata  in  DATA_W  board RAM q; valid the cycle after the address is presented with grant.

Behaviour:
- Reset:
  - State IDLE; req_ready=1.
  - resp_valid, resp_status, dot_eaten, pac_caught, mem_wren = 0.
  - mem_addr=0, mem_wdata=0.
  - under[0..3]=T_EMPTY.
  - Reset mid-operation aborts immediately; no partial write is completed after reset.
- Handshake: a request is accepted on a cycle with req_valid && req_ready. req_agent, req_from and req_to are latched. req_ready is low from the next cycle until the cycle after resp_valid.
- IDLE -> on accept:
  - Illegal agent, req_to >= NUM_CELLS, or req_to == req_from: go to RESP with BLOCKED. No memory access.
  - Otherwise go to RD.
- RD: wait for mem_grant. On grant, mem_addr=to, mem_wren=0, go to CAP.
- CAP: latch tgt=mem_rdata unconditionally and classify.
  - tgt==T_WALL -> BLOCKED.
  - Pac-Man onto a ghost type -> CAUGHT, no writes.
  - Ghost onto T_PAC -> CAUGHT, no writes.
  - Ghost onto another ghost type -> BLOCKED.
  - Any other type -> WR_OLD.
- WR_OLD: wait for grant. Then write mem_addr=from.
  - Pac-Man writes T_EMPTY.
  - Ghost k writes under[k].
  - mem_wren=1 for exactly one granted cycle; go to WR_NEW.
- WR_NEW: wait for grant. Then write mem_addr=to with the agent's block type, one cycle.
  - Ghost k: under[k] <= (tgt==T_DOT ? T_DOT : T_EMPTY).
  - Pac-Man: dot flag <= (tgt==T_DOT).
  - Go to RESP with MOVED.
- RESP: resp_valid=1 for one cycle. dot_eaten=1 iff MOVED and Pac-Man and tgt was T_DOT. pac_caught=1 iff CAUGHT. Next state IDLE.
- mem_wren is never high when mem_grant is low. Grant dropping between WR_OLD and WR_NEW simply stalls.
- Latency with grant held high: accept -> resp_valid = 5 cycles for MOVED (RD, CAP, WR_OLD, WR_NEW, RESP). Rejections from CAP take 3 cycles; off-board requests take 1.
- Types outside the enumerated set are treated as passable and are not remembered by ghosts (under stays or becomes T_EMPTY).

Decomposition:
- Package board_pkg holds:
  - block-type constants (T_*);
  - agent_e enum (PAC, GHOST0..GHOST3);
  - status_e enum (MOVED, BLOCKED, CAUGHT);
  - the board dimension constants (32, 24, 768).
- No sub-module required. The classification of tgt vs agent may be a package function classify_move().

Test Plan:
- Pac-Man, from=495 to=496, cell 496=T_DOT, grant=1 -> writes (495,0),(496,3) in consecutive cycles; resp MOVED 5 cycles after accept; dot_eaten=1.
- Pac-Man to=463 holding T_WALL -> no mem_wren; resp BLOCKED at accept+3; dot_eaten=0.
- Ghost0 crosses T_DOT cell 300 to 301 (301 empty), then 301 to 302 -> on the second move, cell 301 is rewritten with T_EMPTY, not the dot. Separately, 300 to 301 after arriving on dot 300 restores 300=T_DOT.
- Ghost1 to a cell holding T_PAC -> CAUGHT, pac_caught=1, no writes. Pac-Man to a cell holding 4'h6 -> CAUGHT.
- mem_grant toggled 0/1 every 4 cycles during a MOVED sequence -> mem_addr driven and mem_wren high only in grant cycles; write order and final RAM contents unchanged.
- to=800, or req_agent=6 -> BLOCKED next cycle, no RAM read. Reset asserted during WR_OLD -> no WR_NEW write; req_ready=1 the cycle after reset deasserts.
